// File: rtl/instruction_decode.sv
// LEGv8 ID stage: decode, 32x64 register file with write bypass, immediate extension,
// load-use hazard detection, and the ID/EX pipeline register (1-cycle latency).
module instruction_decode #(
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = 64,
  parameter int INSTR_W  = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DATA_W-1:0]  if_pc,
  input  logic [INSTR_W-1:0] if_instr,
  input  logic               if_valid,
  input  logic               wb_regwrite,
  input  logic [4:0]         wb_reg,
  input  logic [DATA_W-1:0]  wb_data,
  input  logic               flush,
  output logic               stall,
  output logic [DATA_W-1:0]  id_ex_AddressI,
  output logic [INSTR_W-1:0] id_ex_InstructionI,
  output logic [DATA_W-1:0]  id_ex_signExtInstrI,
  output logic [DATA_W-1:0]  id_ex_Data1I,
  output logic [DATA_W-1:0]  id_ex_Data2I,
  output logic [1:0]         id_ex_ALUSrcI,
  output logic [1:0]         id_ex_ALUOpI,
  output logic               id_ex_BI,
  output logic               id_ex_BZI,
  output logic               id_ex_BNZI,
  output logic               id_ex_MemWriteI,
  output logic               id_ex_MemReadI,
  output logic               id_ex_MemtoRegI,
  output logic               id_ex_RegWriteI
);

  localparam logic [4:0] XZR = 5'd31;

  logic [DATA_W-1:0] r_regs [NUM_REGS];

  logic [4:0]        w_rn;
  logic [4:0]        w_rm;
  logic              w_rm_is_rt;
  logic [DATA_W-1:0] w_rd1;
  logic [DATA_W-1:0] w_rd2;
  logic [DATA_W-1:0] w_sext;
  logic [1:0]        w_alusrc;
  logic [1:0]        w_aluop;
  logic              w_b;
  logic              w_bz;
  logic              w_bnz;
  logic              w_memwrite;
  logic              w_memread;
  logic              w_memtoreg;
  logic              w_regwrite;
  logic [4:0]        w_ex_rt;
  logic              w_hazard;
  logic              w_stall;
  logic              w_bubble;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (wb_regwrite && wb_reg != XZR) begin
      r_regs[wb_reg] <= wb_data;
    end
  end

  // Opcodes are matched on the top 11 bits; shorter opcodes wildcard the rest.
  always_comb begin
    w_alusrc   = 2'b00;
    w_aluop    = 2'b00;
    w_b        = 1'b0;
    w_bz       = 1'b0;
    w_bnz      = 1'b0;
    w_memwrite = 1'b0;
    w_memread  = 1'b0;
    w_memtoreg = 1'b0;
    w_regwrite = 1'b0;
    w_rm_is_rt = 1'b0;
    w_sext     = '0;
    casez (if_instr[31:21])
      11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000: begin
        w_aluop    = 2'b10;
        w_regwrite = 1'b1;
        w_sext     = {{(DATA_W-12){1'b0}}, if_instr[21:10]};
      end
      11'b1001000100?, 11'b1101000100?: begin
        w_alusrc   = 2'b10;
        w_aluop    = 2'b10;
        w_regwrite = 1'b1;
        w_sext     = {{(DATA_W-12){1'b0}}, if_instr[21:10]};
      end
      11'b11111000010: begin
        w_alusrc   = 2'b01;
        w_memread  = 1'b1;
        w_memtoreg = 1'b1;
        w_regwrite = 1'b1;
        w_sext     = {{(DATA_W-9){if_instr[20]}}, if_instr[20:12]};
      end
      11'b11111000000: begin
        w_alusrc   = 2'b01;
        w_memwrite = 1'b1;
        w_rm_is_rt = 1'b1;
        w_sext     = {{(DATA_W-9){if_instr[20]}}, if_instr[20:12]};
      end
      11'b10110100???: begin
        w_aluop    = 2'b01;
        w_bz       = 1'b1;
        w_rm_is_rt = 1'b1;
        w_sext     = {{(DATA_W-19){if_instr[23]}}, if_instr[23:5]};
      end
      11'b10110101???: begin
        w_aluop    = 2'b01;
        w_bnz      = 1'b1;
        w_rm_is_rt = 1'b1;
        w_sext     = {{(DATA_W-19){if_instr[23]}}, if_instr[23:5]};
      end
      11'b000101?????: begin
        w_b        = 1'b1;
        w_sext     = {{(DATA_W-26){if_instr[25]}}, if_instr[25:0]};
      end
      default: ;
    endcase
  end

  assign w_rn = if_instr[9:5];
  assign w_rm = w_rm_is_rt ? if_instr[4:0] : if_instr[20:16];

  // Writeback in the same cycle as the read is forwarded so decode never sees stale data.
  assign w_rd1 = (w_rn == XZR) ? '0 :
                 (wb_regwrite && wb_reg == w_rn) ? wb_data : r_regs[w_rn];
  assign w_rd2 = (w_rm == XZR) ? '0 :
                 (wb_regwrite && wb_reg == w_rm) ? wb_data : r_regs[w_rm];

  assign w_ex_rt  = id_ex_InstructionI[4:0];
  assign w_hazard = id_ex_MemReadI && (w_ex_rt != XZR) &&
                    ((w_ex_rt == w_rn) || (w_ex_rt == w_rm));
  assign w_stall  = w_hazard && !flush;
  assign w_bubble = !if_valid || flush || w_stall;
  assign stall    = w_stall;

  // A bubble clears only the control bits; datapath fields hold their last value.
  always_ff @(posedge clk) begin
    if (reset) begin
      id_ex_AddressI      <= '0;
      id_ex_InstructionI  <= '0;
      id_ex_signExtInstrI <= '0;
      id_ex_Data1I        <= '0;
      id_ex_Data2I        <= '0;
      id_ex_ALUSrcI       <= 2'b00;
      id_ex_ALUOpI        <= 2'b00;
      id_ex_BI            <= 1'b0;
      id_ex_BZI           <= 1'b0;
      id_ex_BNZI          <= 1'b0;
      id_ex_MemWriteI     <= 1'b0;
      id_ex_MemReadI      <= 1'b0;
      id_ex_MemtoRegI     <= 1'b0;
      id_ex_RegWriteI     <= 1'b0;
    end else if (w_bubble) begin
      id_ex_ALUSrcI       <= 2'b00;
      id_ex_ALUOpI        <= 2'b00;
      id_ex_BI            <= 1'b0;
      id_ex_BZI           <= 1'b0;
      id_ex_BNZI          <= 1'b0;
      id_ex_MemWriteI     <= 1'b0;
      id_ex_MemReadI      <= 1'b0;
      id_ex_MemtoRegI     <= 1'b0;
      id_ex_RegWriteI     <= 1'b0;
    end else begin
      id_ex_AddressI      <= if_pc;
      id_ex_InstructionI  <= if_instr;
      id_ex_signExtInstrI <= w_sext;
      id_ex_Data1I        <= w_rd1;
      id_ex_Data2I        <= w_rd2;
      id_ex_ALUSrcI       <= w_alusrc;
      id_ex_ALUOpI        <= w_aluop;
      id_ex_BI            <= w_b;
      id_ex_BZI           <= w_bz;
      id_ex_BNZI          <= w_bnz;
      id_ex_MemWriteI     <= w_memwrite;
      id_ex_MemReadI      <= w_memread;
      id_ex_MemtoRegI     <= w_memtoreg;
      id_ex_RegWriteI     <= w_regwrite;
    end
  end

endmodule

// File: tb/tb_instruction_decode.sv
// Directed bench for instruction_decode: reset, decode, bypass, XZR, load-use, flush, immediates.
module tb_instruction_decode;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] if_pc;
  logic [31:0] if_instr;
  logic        if_valid;
  logic        wb_regwrite;
  logic [4:0]  wb_reg;
  logic [63:0] wb_data;
  logic        flush;
  logic        stall;
  logic [63:0] id_ex_AddressI;
  logic [31:0] id_ex_InstructionI;
  logic [63:0] id_ex_signExtInstrI;
  logic [63:0] id_ex_Data1I;
  logic [63:0] id_ex_Data2I;
  logic [1:0]  id_ex_ALUSrcI;
  logic [1:0]  id_ex_ALUOpI;
  logic        id_ex_BI, id_ex_BZI, id_ex_BNZI;
  logic        id_ex_MemWriteI, id_ex_MemReadI, id_ex_MemtoRegI, id_ex_RegWriteI;

  int nvec = 0;
  int nerr = 0;

  // {ALUSrc[1:0], ALUOp[1:0], B, BZ, BNZ, MemWrite, MemRead, MemtoReg, RegWrite}
  logic [10:0] ctrl;
  assign ctrl = {id_ex_ALUSrcI, id_ex_ALUOpI, id_ex_BI, id_ex_BZI, id_ex_BNZI,
                 id_ex_MemWriteI, id_ex_MemReadI, id_ex_MemtoRegI, id_ex_RegWriteI};

  localparam logic [10:0] C_NONE = 11'b00_00_0000000;
  localparam logic [10:0] C_RFMT = 11'b00_10_0000001;
  localparam logic [10:0] C_IFMT = 11'b10_10_0000001;
  localparam logic [10:0] C_LDUR = 11'b01_00_0000111;
  localparam logic [10:0] C_STUR = 11'b01_00_0001000;
  localparam logic [10:0] C_CBZ  = 11'b00_01_0100000;
  localparam logic [10:0] C_CBNZ = 11'b00_01_0010000;
  localparam logic [10:0] C_B    = 11'b00_00_1000000;

  instruction_decode dut (
    .clk                 (clk),
    .reset               (reset),
    .if_pc               (if_pc),
    .if_instr            (if_instr),
    .if_valid            (if_valid),
    .wb_regwrite         (wb_regwrite),
    .wb_reg              (wb_reg),
    .wb_data             (wb_data),
    .flush               (flush),
    .stall               (stall),
    .id_ex_AddressI      (id_ex_AddressI),
    .id_ex_InstructionI  (id_ex_InstructionI),
    .id_ex_signExtInstrI (id_ex_signExtInstrI),
    .id_ex_Data1I        (id_ex_Data1I),
    .id_ex_Data2I        (id_ex_Data2I),
    .id_ex_ALUSrcI       (id_ex_ALUSrcI),
    .id_ex_ALUOpI        (id_ex_ALUOpI),
    .id_ex_BI            (id_ex_BI),
    .id_ex_BZI           (id_ex_BZI),
    .id_ex_BNZI          (id_ex_BNZI),
    .id_ex_MemWriteI     (id_ex_MemWriteI),
    .id_ex_MemReadI      (id_ex_MemReadI),
    .id_ex_MemtoRegI     (id_ex_MemtoRegI),
    .id_ex_RegWriteI     (id_ex_RegWriteI)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] enc_add(input logic [4:0] rd, input logic [4:0] rn, input logic [4:0] rm);
    return {11'b10001011000, rm, 6'd0, rn, rd};
  endfunction
  function automatic logic [31:0] enc_d(input logic [10:0] op, input logic [4:0] rt, input logic [4:0] rn, input logic [8:0] imm);
    return {op, imm, 2'b00, rn, rt};
  endfunction
  function automatic logic [31:0] enc_cb(input logic [7:0] op, input logic [4:0] rt, input logic [18:0] imm);
    return {op, imm, rt};
  endfunction
  function automatic logic [31:0] enc_i(input logic [9:0] op, input logic [4:0] rd, input logic [4:0] rn, input logic [11:0] imm);
    return {op, imm, rn, rd};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_write(input logic [4:0] r, input logic [63:0] d);
    if_valid    = 1'b0;
    wb_regwrite = 1'b1;
    wb_reg      = r;
    wb_data     = d;
    step();
    wb_regwrite = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; if_valid = 1'b0; wb_regwrite = 1'b0; wb_reg = '0; wb_data = '0;
    flush = 1'b0; if_pc = '0; if_instr = '0;
    step(); step();
    reset = 1'b0;
    for (int i = 1; i < 31; i++) wb_write(5'(i), 64'hDEAD_0000 + 64'(i));
    if_valid = 1'b1; if_pc = 64'h40; if_instr = enc_add(5'd3, 5'd1, 5'd2);
    step();
    // reset must also beat a writeback pending on the same edge
    reset = 1'b1; wb_regwrite = 1'b1; wb_reg = 5'd9; wb_data = 64'h55;
    step(); step();
    nvec++; if (id_ex_AddressI !== 64'd0) begin nerr++; $display("FAIL reset_addr: got %h want 0", id_ex_AddressI); end
    nvec++; if (id_ex_InstructionI !== 32'd0) begin nerr++; $display("FAIL reset_instr: got %h want 0", id_ex_InstructionI); end
    nvec++; if (id_ex_signExtInstrI !== 64'd0) begin nerr++; $display("FAIL reset_sext: got %h want 0", id_ex_signExtInstrI); end
    nvec++; if (id_ex_Data1I !== 64'd0) begin nerr++; $display("FAIL reset_data1: got %h want 0", id_ex_Data1I); end
    nvec++; if (id_ex_Data2I !== 64'd0) begin nerr++; $display("FAIL reset_data2: got %h want 0", id_ex_Data2I); end
    nvec++; if (ctrl !== C_NONE) begin nerr++; $display("FAIL reset_ctrl: got %b want %b", ctrl, C_NONE); end
    nvec++; if (stall !== 1'b0) begin nerr++; $display("FAIL reset_stall: got %b want 0", stall); end
    reset = 1'b0; wb_regwrite = 1'b0; if_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if_instr = enc_add(5'd0, 5'(2*i), 5'(2*i+1));
      step();
      nvec++; if (id_ex_Data1I !== 64'd0) begin nerr++; $display("FAIL reset_reg X%0d: got %h want 0", 2*i, id_ex_Data1I); end
      nvec++; if (id_ex_Data2I !== 64'd0) begin nerr++; $display("FAIL reset_reg X%0d: got %h want 0", 2*i+1, id_ex_Data2I); end
    end
  endtask

  task automatic test_add();
    wb_write(5'd1, 64'd5);
    wb_write(5'd2, 64'd7);
    if_valid = 1'b1; if_pc = 64'h1000; if_instr = enc_add(5'd3, 5'd1, 5'd2);
    step();
    nvec++; if (id_ex_Data1I !== 64'd5) begin nerr++; $display("FAIL add_data1: got %h want 5", id_ex_Data1I); end
    nvec++; if (id_ex_Data2I !== 64'd7) begin nerr++; $display("FAIL add_data2: got %h want 7", id_ex_Data2I); end
    nvec++; if (ctrl !== C_RFMT) begin nerr++; $display("FAIL add_ctrl: got %b want %b", ctrl, C_RFMT); end
    nvec++; if (id_ex_AddressI !== 64'h1000) begin nerr++; $display("FAIL add_addr: got %h want 1000", id_ex_AddressI); end
    nvec++; if (id_ex_InstructionI !== 32'h8B02_0023) begin nerr++; $display("FAIL add_instr: got %h want 8b020023", id_ex_InstructionI); end
    nvec++; if (id_ex_signExtInstrI !== 64'h80) begin nerr++; $display("FAIL add_sext: got %h want 80", id_ex_signExtInstrI); end
  endtask

  task automatic test_bypass();
    wb_regwrite = 1'b1; wb_reg = 5'd4; wb_data = 64'hAA;
    if_valid = 1'b1; if_instr = enc_add(5'd5, 5'd4, 5'd4);
    step();
    wb_regwrite = 1'b0;
    nvec++; if (id_ex_Data1I !== 64'hAA) begin nerr++; $display("FAIL bypass_data1: got %h want aa", id_ex_Data1I); end
    nvec++; if (id_ex_Data2I !== 64'hAA) begin nerr++; $display("FAIL bypass_data2: got %h want aa", id_ex_Data2I); end
    if_instr = enc_add(5'd6, 5'd4, 5'd2);
    step();
    nvec++; if (id_ex_Data1I !== 64'hAA) begin nerr++; $display("FAIL bypass_stored: got %h want aa", id_ex_Data1I); end
  endtask

  task automatic test_xzr();
    wb_write(5'd31, 64'd9);
    if_valid = 1'b1; if_instr = enc_add(5'd1, 5'd31, 5'd31);
    step();
    nvec++; if (id_ex_Data1I !== 64'd0) begin nerr++; $display("FAIL xzr_data1: got %h want 0", id_ex_Data1I); end
    nvec++; if (id_ex_Data2I !== 64'd0) begin nerr++; $display("FAIL xzr_data2: got %h want 0", id_ex_Data2I); end
    wb_regwrite = 1'b1; wb_reg = 5'd31; wb_data = 64'd9;
    step();
    wb_regwrite = 1'b0;
    nvec++; if (id_ex_Data1I !== 64'd0) begin nerr++; $display("FAIL xzr_bypass: got %h want 0", id_ex_Data1I); end
  endtask

  task automatic test_load_use();
    wb_write(5'd1, 64'h100);
    if_valid = 1'b1; if_pc = 64'h200; if_instr = enc_d(11'b11111000010, 5'd2, 5'd1, 9'd8);
    step();
    nvec++; if (ctrl !== C_LDUR) begin nerr++; $display("FAIL ldur_ctrl: got %b want %b", ctrl, C_LDUR); end
    nvec++; if (id_ex_signExtInstrI !== 64'd8) begin nerr++; $display("FAIL ldur_sext: got %h want 8", id_ex_signExtInstrI); end
    nvec++; if (id_ex_Data1I !== 64'h100) begin nerr++; $display("FAIL ldur_data1: got %h want 100", id_ex_Data1I); end
    if_pc = 64'h204; if_instr = enc_add(5'd3, 5'd2, 5'd2);
    #1;
    nvec++; if (stall !== 1'b1) begin nerr++; $display("FAIL lu_stall: got %b want 1", stall); end
    step();
    nvec++; if (ctrl !== C_NONE) begin nerr++; $display("FAIL lu_bubble: got %b want %b", ctrl, C_NONE); end
    nvec++; if (stall !== 1'b0) begin nerr++; $display("FAIL lu_stall_once: got %b want 0", stall); end
    step();
    nvec++; if (ctrl !== C_RFMT) begin nerr++; $display("FAIL lu_issue_ctrl: got %b want %b", ctrl, C_RFMT); end
    nvec++; if (id_ex_InstructionI !== 32'h8B02_0043) begin nerr++; $display("FAIL lu_issue_instr: got %h want 8b020043", id_ex_InstructionI); end
    // independent consumer: no stall
    if_instr = enc_d(11'b11111000010, 5'd2, 5'd1, 9'd8);
    step();
    if_instr = enc_add(5'd3, 5'd5, 5'd6);
    #1;
    nvec++; if (stall !== 1'b0) begin nerr++; $display("FAIL lu_nodep: got %b want 0", stall); end
    // load into XZR never creates a dependency
    if_instr = enc_d(11'b11111000010, 5'd31, 5'd1, 9'd8);
    step();
    if_instr = enc_add(5'd3, 5'd31, 5'd31);
    #1;
    nvec++; if (stall !== 1'b0) begin nerr++; $display("FAIL lu_xzr: got %b want 0", stall); end
    step();
  endtask

  task automatic test_flush_stall();
    if_valid = 1'b1; if_instr = enc_d(11'b11111000010, 5'd2, 5'd1, 9'd8);
    step();
    if_instr = enc_add(5'd3, 5'd2, 5'd2); flush = 1'b1;
    #1;
    nvec++; if (stall !== 1'b0) begin nerr++; $display("FAIL flush_stall: got %b want 0", stall); end
    step();
    flush = 1'b0;
    nvec++; if (ctrl !== C_NONE) begin nerr++; $display("FAIL flush_bubble: got %b want %b", ctrl, C_NONE); end
    if_valid = 1'b0; if_instr = enc_add(5'd3, 5'd1, 5'd2);
    step();
    nvec++; if (ctrl !== C_NONE) begin nerr++; $display("FAIL invalid_bubble: got %b want %b", ctrl, C_NONE); end
  endtask

  task automatic test_branch_imm();
    wb_write(5'd7, 64'h77);
    if_valid = 1'b1; if_instr = enc_cb(8'b10110100, 5'd7, 19'h7FFFF);
    step();
    nvec++; if (id_ex_signExtInstrI !== 64'hFFFF_FFFF_FFFF_FFFF) begin nerr++; $display("FAIL cbz_sext: got %h want ffffffffffffffff", id_ex_signExtInstrI); end
    nvec++; if (ctrl !== C_CBZ) begin nerr++; $display("FAIL cbz_ctrl: got %b want %b", ctrl, C_CBZ); end
    nvec++; if (id_ex_Data2I !== 64'h77) begin nerr++; $display("FAIL cbz_rt: got %h want 77", id_ex_Data2I); end
    if_instr = enc_cb(8'b10110101, 5'd7, 19'h00001);
    step();
    nvec++; if (id_ex_signExtInstrI !== 64'd1) begin nerr++; $display("FAIL cbnz_sext: got %h want 1", id_ex_signExtInstrI); end
    nvec++; if (ctrl !== C_CBNZ) begin nerr++; $display("FAIL cbnz_ctrl: got %b want %b", ctrl, C_CBNZ); end
    if_instr = {6'b000101, 26'h3FF_FFFE};
    step();
    nvec++; if (id_ex_signExtInstrI !== 64'hFFFF_FFFF_FFFF_FFFE) begin nerr++; $display("FAIL b_sext: got %h want fffffffffffffffe", id_ex_signExtInstrI); end
    nvec++; if (ctrl !== C_B) begin nerr++; $display("FAIL b_ctrl: got %b want %b", ctrl, C_B); end
  endtask

  task automatic test_misc_decode();
    if_valid = 1'b1; if_instr = enc_i(10'b1001000100, 5'd1, 5'd2, 12'hFFF);
    step();
    nvec++; if (id_ex_signExtInstrI !== 64'hFFF) begin nerr++; $display("FAIL addi_sext: got %h want fff", id_ex_signExtInstrI); end
    nvec++; if (ctrl !== C_IFMT) begin nerr++; $display("FAIL addi_ctrl: got %b want %b", ctrl, C_IFMT); end
    if_instr = enc_d(11'b11111000000, 5'd7, 5'd1, 9'h1F8);
    step();
    nvec++; if (id_ex_signExtInstrI !== 64'hFFFF_FFFF_FFFF_FFF8) begin nerr++; $display("FAIL stur_sext: got %h want fffffffffffffff8", id_ex_signExtInstrI); end
    nvec++; if (ctrl !== C_STUR) begin nerr++; $display("FAIL stur_ctrl: got %b want %b", ctrl, C_STUR); end
    nvec++; if (id_ex_Data2I !== 64'h77) begin nerr++; $display("FAIL stur_rt: got %h want 77", id_ex_Data2I); end
    nvec++; if (id_ex_Data1I !== 64'h100) begin nerr++; $display("FAIL stur_rn: got %h want 100", id_ex_Data1I); end
    if_instr = {11'b11001011000, 5'd2, 6'd0, 5'd1, 5'd3};
    step();
    nvec++; if (ctrl !== C_RFMT) begin nerr++; $display("FAIL sub_ctrl: got %b want %b", ctrl, C_RFMT); end
    if_instr = 32'h0000_0000;
    step();
    nvec++; if (ctrl !== C_NONE) begin nerr++; $display("FAIL unknown_ctrl: got %b want %b", ctrl, C_NONE); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_bypass();
    test_xzr();
    test_load_use();
    test_flush_stall();
    test_branch_imm();
    test_misc_decode();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
